// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - instruction sequencer FSM (IDLE/FETCH/EXEC/MEM/HALT) with branch unit and cycle counter
//
// Ports:
//   Clk, Reset_n          clock, synchronous active-low reset
//   Start                 one-cycle pulse; launches a program from IDLE or HALT
//   ConditionalJump       decoded branch; BranchAbsOrRel selects absolute/relative,
//   BranchConditions      00 always, 01 Z, 10 N, 11 not-Z (against latched flags)
//   BranchTarget          absolute address or two's-complement offset
//   LoadInst, MemWrEn     decoded load / store; go through MEM
//   Ack                   decoded halt
//   FlagWrEn, FlagZ/N     flag latch enable and ALU flags
//   MemAck                data memory completion (only looked at in MEM)
//   ProgCtr               instruction ROM address
//   ExecEn                instruction word valid (EXEC and MEM)
//   RegWrGate, MemWrGate  register-file / memory write qualifiers
//   MemReq                memory request, held through MEM
//   Busy, Done            running / halted status
//   CycleCount            saturating count of busy cycles since Start
module prog_sequencer (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic        ConditionalJump,
    input  logic        BranchAbsOrRel,
    input  logic [1:0]  BranchConditions,
    input  logic [9:0]  BranchTarget,
    input  logic        LoadInst,
    input  logic        MemWrEn,
    input  logic        Ack,
    input  logic        FlagWrEn,
    input  logic        FlagZ,
    input  logic        FlagN,
    input  logic        MemAck,
    output logic [9:0]  ProgCtr,
    output logic        ExecEn,
    output logic        RegWrGate,
    output logic        MemWrGate,
    output logic        MemReq,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] CycleCount
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [9:0] pc_nxt;
    logic [9:0] pc_inc;
    logic [9:0] pc_branch;
    logic       zl;
    logic       nl;
    logic       mem_load;
    logic       cond_true;
    logic       launch;

    // 10-bit adders wrap naturally, which gives the modulo-1024 behaviour
    // for both the increment and negative relative offsets.
    assign pc_inc    = ProgCtr + 10'd1;
    assign pc_branch = BranchAbsOrRel ? (ProgCtr + BranchTarget) : BranchTarget;
    assign launch    = Start && ((state == IDLE) || (state == HALT));

    always_comb begin
        cond_true = 1'b1;
        case (BranchConditions)
            2'b00:   cond_true = 1'b1;
            2'b01:   cond_true = zl;
            2'b10:   cond_true = nl;
            default: cond_true = !zl;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = ProgCtr;
        case (state)
            IDLE, HALT: begin
                if (Start) begin
                    state_nxt = FETCH;
                    pc_nxt    = 10'd0;
                end
            end
            FETCH: state_nxt = EXEC;
            EXEC: begin
                if (Ack) begin
                    state_nxt = HALT;
                end else if (LoadInst || MemWrEn) begin
                    state_nxt = MEM;
                end else begin
                    state_nxt = FETCH;
                    pc_nxt    = (ConditionalJump && cond_true) ? pc_branch : pc_inc;
                end
            end
            MEM: begin
                if (MemAck) begin
                    state_nxt = FETCH;
                    pc_nxt    = pc_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = 10'd0;
            end
        endcase
    end

    // The write gates qualify the instruction completing in this very cycle,
    // so they are decoded from the current state and the live decode/ack
    // inputs rather than registered (a registered pulse would land in FETCH).
    assign RegWrGate = ((state == EXEC) && !Ack && !LoadInst && !MemWrEn && !ConditionalJump)
                     || ((state == MEM) && MemAck && mem_load);
    assign MemWrGate = (state == MEM) && MemAck && !mem_load;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            ProgCtr    <= 10'd0;
            CycleCount <= 16'd0;
            zl         <= 1'b0;
            nl         <= 1'b0;
            mem_load   <= 1'b0;
            ExecEn     <= 1'b0;
            MemReq     <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state   <= state_nxt;
            ProgCtr <= pc_nxt;
            ExecEn  <= (state_nxt == EXEC) || (state_nxt == MEM);
            MemReq  <= (state_nxt == MEM);
            Busy    <= (state_nxt == FETCH) || (state_nxt == EXEC) || (state_nxt == MEM);
            Done    <= (state_nxt == HALT);

            if (launch) begin
                CycleCount <= 16'd0;
                zl         <= 1'b0;
                nl         <= 1'b0;
            end else begin
                // Busy mirrors the current state, so this counts busy cycles
                // and naturally holds the count in HALT and IDLE.
                if (Busy && (CycleCount != 16'hFFFF)) begin
                    CycleCount <= CycleCount + 16'd1;
                end
                // Written at the end of EXEC, so a branch in this same cycle
                // still sees the flags from before it.
                if ((state == EXEC) && FlagWrEn) begin
                    zl <= FlagZ;
                    nl <= FlagN;
                end
            end

            // Remember load vs store for the MEM completion cycle.
            if (state == EXEC) begin
                mem_load <= LoadInst;
            end
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - self-checking bench for prog_sequencer with instruction-level reference model
module tb_prog_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        ConditionalJump = 1'b0;
    logic        BranchAbsOrRel = 1'b0;
    logic [1:0]  BranchConditions = 2'b00;
    logic [9:0]  BranchTarget = 10'd0;
    logic        LoadInst = 1'b0;
    logic        MemWrEn = 1'b0;
    logic        Ack = 1'b0;
    logic        FlagWrEn = 1'b0;
    logic        FlagZ = 1'b0;
    logic        FlagN = 1'b0;
    logic        MemAck = 1'b0;
    logic [9:0]  ProgCtr;
    logic        ExecEn;
    logic        RegWrGate;
    logic        MemWrGate;
    logic        MemReq;
    logic        Busy;
    logic        Done;
    logic [15:0] CycleCount;

    prog_sequencer dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .Start            (Start),
        .ConditionalJump  (ConditionalJump),
        .BranchAbsOrRel   (BranchAbsOrRel),
        .BranchConditions (BranchConditions),
        .BranchTarget     (BranchTarget),
        .LoadInst         (LoadInst),
        .MemWrEn          (MemWrEn),
        .Ack              (Ack),
        .FlagWrEn         (FlagWrEn),
        .FlagZ            (FlagZ),
        .FlagN            (FlagN),
        .MemAck           (MemAck),
        .ProgCtr          (ProgCtr),
        .ExecEn           (ExecEn),
        .RegWrGate        (RegWrGate),
        .MemWrGate        (MemWrGate),
        .MemReq           (MemReq),
        .Busy             (Busy),
        .Done             (Done),
        .CycleCount       (CycleCount)
    );

    always #5 Clk = ~Clk;

    localparam int K_ALU  = 0;
    localparam int K_BR   = 1;
    localparam int K_LD   = 2;
    localparam int K_ST   = 3;
    localparam int K_HALT = 4;

    int n_vec = 0;
    int n_err = 0;

    // reference model: program-level view
    int m_pc;
    int m_cc;
    bit m_zl;
    bit m_nl;
    bit m_busy;

    // per-scenario observation counters
    int g_regwr;
    int g_mreq;
    int g_memregwr;
    int g_memwr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_decode();
        ConditionalJump  = 1'b0;
        BranchAbsOrRel   = 1'b0;
        BranchConditions = 2'b00;
        BranchTarget     = 10'd0;
        LoadInst         = 1'b0;
        MemWrEn          = 1'b0;
        Ack              = 1'b0;
        FlagWrEn         = 1'b0;
        FlagZ            = 1'b0;
        FlagN            = 1'b0;
        MemAck           = 1'b0;
    endtask

    // One clock: the model counts the cycle if the program was running before the edge.
    task automatic clk_step();
        if (m_busy && (m_cc < 65535)) m_cc++;
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_start();
        Start = 1'b1;
        clk_step();
        Start = 1'b0;
        m_pc = 0;
        m_cc = 0;
        m_zl = 1'b0;
        m_nl = 1'b0;
        m_busy = 1'b1;
        check("start_busy",   32'(Busy), 1);
        check("start_done",   32'(Done), 0);
        check("start_execen", 32'(ExecEn), 0);
        check("start_pc",     32'(ProgCtr), 0);
        check("start_cc",     32'(CycleCount), 0);
    endtask

    // Runs one instruction, entered and left at the negedge of its FETCH cycle.
    task automatic run_instr(input int kind, input logic [1:0] cond, input logic rel,
                             input logic [9:0] tgt, input logic fwe, input logic fz,
                             input logic fn, input logic cj, input int ack_delay,
                             input logic poke);
        int  nxt;
        int  off;
        bit  taken;
        bit  is_ld;
        bit  is_st;
        is_ld = (kind == K_LD);
        is_st = (kind == K_ST);

        check("fetch_pc",     32'(ProgCtr), m_pc);
        check("fetch_execen", 32'(ExecEn), 0);
        check("fetch_cc",     32'(CycleCount), m_cc);
        check("fetch_gates",  32'({RegWrGate, MemWrGate, MemReq}), 0);
        clk_step();

        ConditionalJump  = (kind == K_BR) || ((kind == K_HALT) && cj);
        BranchConditions = cond;
        BranchAbsOrRel   = rel;
        BranchTarget     = tgt;
        LoadInst         = is_ld;
        MemWrEn          = is_st;
        Ack              = (kind == K_HALT);
        FlagWrEn         = fwe;
        FlagZ            = fz;
        FlagN            = fn;
        Start            = poke;
        MemAck           = poke;
        #1;
        check("exec_en",     32'(ExecEn), 1);
        check("exec_pc",     32'(ProgCtr), m_pc);
        check("exec_busy",   32'(Busy), 1);
        check("exec_regwr",  32'(RegWrGate), 32'(kind == K_ALU));
        check("exec_memwr",  32'(MemWrGate), 0);
        check("exec_memreq", 32'(MemReq), 0);
        if (RegWrGate === 1'b1) g_regwr++;

        case (cond)
            2'b00:   taken = 1'b1;
            2'b01:   taken = m_zl;
            2'b10:   taken = m_nl;
            default: taken = !m_zl;
        endcase
        off = (int'(tgt) >= 512) ? int'(tgt) - 1024 : int'(tgt);
        if (kind == K_BR) begin
            if (!taken)   nxt = (m_pc + 1) % 1024;
            else if (rel) nxt = ((m_pc + off) % 1024 + 1024) % 1024;
            else          nxt = int'(tgt);
        end else if (kind == K_ALU) begin
            nxt = (m_pc + 1) % 1024;
        end else begin
            nxt = m_pc;
        end
        if (fwe) begin
            m_zl = fz;
            m_nl = fn;
        end
        clk_step();
        Start  = 1'b0;
        MemAck = 1'b0;

        if (is_ld || is_st) begin
            for (int d = 0; d <= ack_delay; d++) begin
                MemAck = (d == ack_delay);
                #1;
                if (d < 4 || d == ack_delay) begin
                    check("mem_req",   32'(MemReq), 1);
                    check("mem_execen", 32'(ExecEn), 1);
                    check("mem_regwr", 32'(RegWrGate), 32'(is_ld && (d == ack_delay)));
                    check("mem_memwr", 32'(MemWrGate), 32'(is_st && (d == ack_delay)));
                    check("mem_pc",    32'(ProgCtr), m_pc);
                end
                if (MemReq === 1'b1) g_mreq++;
                if (RegWrGate === 1'b1) g_memregwr++;
                if (MemWrGate === 1'b1) g_memwr++;
                clk_step();
            end
            MemAck = 1'b0;
            nxt = (m_pc + 1) % 1024;
        end
        clear_decode();
        m_pc = nxt;

        if (kind == K_HALT) begin
            m_busy = 1'b0;
            check("halt_done",  32'(Done), 1);
            check("halt_busy",  32'(Busy), 0);
            check("halt_pc",    32'(ProgCtr), m_pc);
            check("halt_cc",    32'(CycleCount), m_cc);
            check("halt_gates", 32'({RegWrGate, MemWrGate, MemReq, ExecEn}), 0);
        end
    endtask

    task automatic alu();
        run_instr(K_ALU, 2'b00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    initial begin
        m_pc = 0; m_cc = 0; m_zl = 0; m_nl = 0; m_busy = 0;
        g_regwr = 0; g_mreq = 0; g_memregwr = 0; g_memwr = 0;

        // reset state
        Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_pc",    32'(ProgCtr), 0);
        check("rst_cc",    32'(CycleCount), 0);
        check("rst_outs",  32'({ExecEn, RegWrGate, MemWrGate, MemReq, Busy, Done}), 0);
        Reset_n = 1'b1;
        clk_step();
        check("idle_busy", 32'(Busy), 0);

        // three ALU ops then halt overlapping a branch decode
        do_start();
        g_regwr = 0;
        alu(); alu(); alu();
        run_instr(K_HALT, 2'b00, 1'b0, 10'd500, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("s1_regwr_pulses", 32'(g_regwr), 3);
        check("s1_pc",   32'(ProgCtr), 3);
        check("s1_cc",   32'(CycleCount), 8);
        check("s1_done", 32'(Done), 1);
        repeat (3) clk_step();
        check("s1_hold_cc", 32'(CycleCount), 8);

        // conditional branch on latched Z, taken and not taken
        do_start();
        run_instr(K_ALU, 2'b00, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_instr(K_BR,  2'b01, 1'b0, 10'd200, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("s2_taken_pc", 32'(ProgCtr), 200);
        run_instr(K_ALU, 2'b00, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_instr(K_BR,  2'b01, 1'b0, 10'd200, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("s2_nottaken_pc", 32'(ProgCtr), 202);
        run_instr(K_HALT, 2'b00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // negative relative branch and increment wrap (restart from HALT)
        do_start();
        alu(); alu();
        run_instr(K_BR, 2'b00, 1'b1, 10'h3FC, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("s3_rel_pc", 32'(ProgCtr), 1022);
        alu(); alu();
        check("s3_wrap_pc", 32'(ProgCtr), 0);
        run_instr(K_HALT, 2'b00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // load with late MemAck, store with immediate MemAck, Start poked in EXEC
        do_start();
        g_mreq = 0; g_memregwr = 0; g_memwr = 0;
        run_instr(K_LD, 2'b00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        check("s4_memreq_cycles", 32'(g_mreq), 4);
        check("s4_regwr_pulses",  32'(g_memregwr), 1);
        check("s4_pc",            32'(ProgCtr), 1);
        g_mreq = 0;
        run_instr(K_ST, 2'b00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("s4_st_memreq", 32'(g_mreq), 1);
        check("s4_st_memwr",  32'(g_memwr), 1);
        check("s4_st_pc",     32'(ProgCtr), 2);
        run_instr(K_ALU, 2'b00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        check("s5_start_ignored_pc", 32'(ProgCtr), 3);

        // reset during MEM, with Start on the same edge
        clk_step();
        LoadInst = 1'b1;
        clk_step();
        check("s5_in_mem", 32'(MemReq), 1);
        Reset_n = 1'b0;
        Start = 1'b1;
        m_busy = 1'b0;
        clk_step();
        check("s5_rst_memreq", 32'(MemReq), 0);
        check("s5_rst_pc",     32'(ProgCtr), 0);
        check("s5_rst_cc",     32'(CycleCount), 0);
        check("s5_rst_outs",   32'({ExecEn, RegWrGate, MemWrGate, Busy, Done}), 0);
        Reset_n = 1'b1;
        Start = 1'b0;
        clk_step();
        check("s5_idle_after", 32'({Busy, RegWrGate, MemReq}), 0);
        LoadInst = 1'b0;

        // randomized programs
        for (int p = 0; p < 6; p++) begin
            do_start();
            for (int i = 0; i < 50; i++) begin
                run_instr($urandom_range(0, 3), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                          $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0));
            end
            run_instr(K_HALT, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      10'($urandom_range(0, 1023)), 1'b0, 1'b0, 1'b0,
                      1'($urandom_range(0, 1)), 0, 1'b0);
            repeat (2) clk_step();
            check("rand_hold_pc", 32'(ProgCtr), m_pc);
            check("rand_hold_cc", 32'(CycleCount), m_cc);
        end

        // long MEM stall, counter saturation, then hold in HALT
        do_start();
        run_instr(K_LD, 2'b00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 69990, 1'b0);
        check("s6_cc_sat", 32'(CycleCount), 32'hFFFF);
        run_instr(K_HALT, 2'b00, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) clk_step();
        check("s6_cc_hold", 32'(CycleCount), 32'hFFFF);
        check("s6_done",    32'(Done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
- Clk  in  1  single clock; all state updates on rising edge
- Reset_n  in  1  synchronous, active-low reset
- Start  in  1  one-cycle pulse that launches a program
- ConditionalJump  in  1  decoded branch instruction
- BranchAbsOrRel  in  1  0 = absolute, 1 = relative
- BranchConditions  in  2  00 always, 01 Z, 10 N, 11 not-Z
- BranchTarget  in  10  lookup-table value; absolute address or two's-complement offset
- LoadInst  in  1  decoded load
- MemWrEn  in  1  decoded store
- Ack  in  1  decoded halt instruction
- FlagWrEn  in  1  CMP executing; latch FlagZ and FlagN
- FlagZ, FlagN  in  1 each  ALU flags
- MemAck  in  1  data memory completion
- ProgCtr  out  10  instruction ROM address
- ExecEn  out  1  instruction word valid this cycle
- RegWrGate  out  1  qualifies register-file write
- MemWrGate  out  1  qualifies memory write
- MemReq  out  1  memory request
- Busy  out  1  program running
- Done  out  1  program halted
- CycleCount  out  16  cycles since Start

Function
REQ-002 SHALL implement a state machine with states IDLE, FETCH, EXEC, MEM and HALT.
REQ-003 SHALL move from IDLE or HALT to FETCH on Start=1, and on that edge SHALL load ProgCtr=0, CycleCount=0 and clear the latched flags Zl/Nl.
REQ-004 SHALL ignore Start while in FETCH, EXEC or MEM.
REQ-005 FETCH SHALL last exactly one cycle (synchronous ROM read) and then go to EXEC; ExecEn=1 only in EXEC and MEM.
REQ-006 In EXEC, SHALL apply the following priority: Ack, then LoadInst/MemWrEn, then ConditionalJump, then default.
REQ-007 Ack=1 in EXEC SHALL go to HALT with ProgCtr unchanged, RegWrGate=0 and MemWrGate=0; Ack takes priority over the branch decode it overlaps.
REQ-008 LoadInst or MemWrEn in EXEC SHALL go to MEM; MemReq=1 in MEM only, held until MemAck=1.
REQ-009 In MEM with MemAck=1, SHALL assert RegWrGate=1 (load) or MemWrGate=1 (store) for that cycle only, set ProgCtr+=1 and go to FETCH.
REQ-010 MemAck SHALL be ignored outside MEM; MEM has no timeout.
REQ-011 ConditionalJump in EXEC SHALL evaluate its condition against the latched Zl/Nl; if the branch is taken, ProgCtr <= BranchTarget (absolute) or ProgCtr + BranchTarget mod 1024 (relative); otherwise ProgCtr += 1; RegWrGate=0.
REQ-012 For any other instruction in EXEC, SHALL assert RegWrGate=1 for one cycle, set ProgCtr+=1 and go to FETCH.
REQ-013 Zl/Nl SHALL update only on an EXEC cycle with FlagWrEn=1; a branch SHALL use the flags latched before its own EXEC cycle.
REQ-014 ProgCtr increment SHALL wrap 1023 to 0; relative targets SHALL wrap modulo 1024 in both directions.
REQ-015 Busy SHALL be 1 in FETCH, EXEC and MEM; Done SHALL be 1 in HALT only; both SHALL be 0 in IDLE.
REQ-016 CycleCount SHALL increment every cycle while Busy=1, saturate at 16'hFFFF, and hold in HALT.
REQ-017 RegWrGate, MemWrGate and MemReq SHALL never be asserted in IDLE, FETCH or HALT.

Reset
REQ-018 Reset_n=0 at a clock edge SHALL force IDLE, ProgCtr=0, CycleCount=0, Zl=Nl=0, and all outputs 0, from any state including MEM mid-request.
REQ-019 Reset SHALL take priority over Start on the same edge.

Verification
REQ-020 Bench SHALL cover the following scenarios.
- Start, then 3 ALU instructions, then Ack -> PCs 0,1,2,3; RegWrGate pulses 3 times; Done=1 with ProgCtr=3; CycleCount=8.
- CMP (FlagZ=1), then branch cond 01, absolute, BranchTarget=200 -> ProgCtr=200; same with FlagZ=0 -> ProgCtr=PC+1.
- Relative branch at PC=2 with BranchTarget=10'h3FC (-4) -> ProgCtr=1022; ALU instruction at PC=1023 -> ProgCtr=0.
- Load with MemAck delayed 3 cycles -> MemReq high 4 cycles, a single RegWrGate pulse on the MemAck cycle, ProgCtr+1.
- Reset_n=0 during MEM -> next cycle IDLE, MemReq=0, ProgCtr=0; Start in EXEC is ignored.
- 70000 cycles without Ack -> CycleCount=16'hFFFF.
